array_2_arb: RTL and testbench
==============================

ARRAY_2_ARB -- requirements
Module: array_2_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning SRAM word-address width (depth 2^ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 76, meaning SRAM word width in bits.
REQ-003 SHALL have parameter MASK_W, default 4, meaning number of write-mask lanes.
REQ-004 SHALL have parameter INIT_EN, default 1, meaning 1 = zero-fill the whole array after reset, 0 = skip fill.
REQ-005 SHALL have ports: clock  in  1  single clock for all logic; the SRAM shares this clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 w_valid  in  1; w_ready  out  1; w_addr  in  ADDR_W; w_data  in  DATA_W; w_mask  in  MASK_W: write-requester handshake.
REQ-008 r_valid  in  1; r_ready  out  1; r_addr  in  ADDR_W: read-requester handshake.
REQ-009 r_resp_valid  out  1; r_resp_data  out  DATA_W: read response.
REQ-010 init_done  out  1: high once the fill has completed, or immediately after reset when INIT_EN=0.
REQ-011 RW0_addr  out  ADDR_W; RW0_en  out  1; RW0_wmode  out  1; RW0_wdata  out  DATA_W; RW0_wmask  out  MASK_W; RW0_rdata  in  DATA_W: single-port SRAM. The SRAM has read latency 1, and RW0_rdata is valid only in the cycle after a read enable.

Function
REQ-012 SHALL implement FSM states INIT and RUN; reset enters INIT if INIT_EN=1, else RUN.
REQ-013 INIT SHALL use a counter starting at 0.
- Each cycle: RW0_en=1, RW0_wmode=1, RW0_addr=counter, RW0_wdata=0, RW0_wmask=all ones.
- Counter increments by 1 each cycle.
- After the write to address 2^ADDR_W-1, the FSM moves to RUN and sets init_done=1; the fill takes exactly 2^ADDR_W cycles.
- The counter stops there and never wraps.
REQ-014 In INIT, w_ready=0 and r_ready=0; requests are not consumed.
REQ-015 In RUN, a request is accepted in the same cycle as valid&&ready.
- w_ready and r_ready are combinational.
- At most one of w_ready and r_ready is high in any cycle.
REQ-016 Arbitration in RUN:
- Only one valid: that requester is granted.
- Both valid: the requester named by a 1-bit priority pointer is granted.
- After every accepted grant, the pointer points to the other requester.
- Pointer reset value: write.
REQ-017 Accepted write SHALL drive, in the same cycle, RW0_en=1, RW0_wmode=1, RW0_addr=w_addr, RW0_wdata=w_data, RW0_wmask=w_mask. A w_mask of 0 is still accepted and consumes the slot.
REQ-018 Accepted read SHALL drive, in the same cycle, RW0_en=1, RW0_wmode=0, RW0_addr=r_addr, RW0_wmask=0.
REQ-019 Read pipeline timing, for a read accepted in cycle T:
- A pending flag is set for cycle T+1.
- At the end of T+1, RW0_rdata is captured into the r_resp_data register.
- r_resp_valid=1 for exactly cycle T+2.
- r_resp_data holds its value until the next capture.
REQ-020 Reads SHALL sustain one per cycle; back-to-back reads give back-to-back r_resp_valid pulses in request order.
REQ-021 A write accepted in T followed by a read to the same address accepted in T+1 SHALL return the written data, masked by lane.
REQ-022 When no request is accepted, RW0_en=0, RW0_wmode=0, RW0_wmask=0; RW0_addr and RW0_wdata are don't-care.
REQ-023 Requesters SHALL hold valid and payload stable until accepted; the block has no input buffering.

Reset
REQ-024 Asynchronous reset SHALL immediately force the following values:
- FSM to INIT (or RUN when INIT_EN=0); init counter=0; priority pointer=write.
- Pending flag=0, r_resp_valid=0, r_resp_data=0.
- init_done=0 (1 when INIT_EN=0).
- RW0_en=0, RW0_wmode=0, w_ready=0, r_ready=0.
REQ-025 Reset asserted during INIT or RUN SHALL restart the fill from address 0. An in-flight read response is discarded and never pulses r_resp_valid.

Verification
REQ-026 Reset, INIT_EN=1, ADDR_W=9 -> 512 consecutive writes, addresses 0..511, data 0, mask 4'hF; init_done rises the cycle after address 511; no ready during the fill.
REQ-027 After init, write addr 5, data D, mask 4'hF, then read addr 5 the next cycle -> r_resp_valid two cycles after the read is accepted, with data D.
REQ-028 w_valid and r_valid held high together for 4 cycles -> grants in order W, R, W, R; never both ready in one cycle.
REQ-029 Write addr 7 with mask 4'b0010 over a zeroed word, then read addr 7 -> only lane 1 (bits 37:19) changed.
REQ-030 Reads to addresses 1, 2, 3 on consecutive cycles -> three consecutive r_resp_valid pulses with the data of 1, 2, 3 in that order.
REQ-031 Reset asserted during INIT at counter=200, and separately one cycle after a read is accepted -> fill restarts at address 0; no r_resp_valid pulse appears.

Source files
------------

// File: rtl/array_2_arb.sv
// Two-requester arbiter in front of a single-port SRAM: zero-fills the array after reset,
// then grants one write or one read per cycle with a toggling priority pointer.
module array_2_arb #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 76,
  parameter int MASK_W  = 4,
  parameter int INIT_EN = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [MASK_W-1:0] w_mask,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              r_resp_valid,
  output logic [DATA_W-1:0] r_resp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [DATA_W-1:0] RW0_wdata,
  output logic [MASK_W-1:0] RW0_wmask,
  input  logic [DATA_W-1:0] RW0_rdata
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam state_t            RESET_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;
  localparam logic              PRIO_W      = 1'b0;
  localparam logic              PRIO_R      = 1'b1;

  state_t            state, state_next;
  logic [ADDR_W-1:0] init_cnt, init_cnt_next;
  logic              prio, prio_next;
  logic              rd_pending;
  logic              r_accept;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= RESET_STATE;
      init_cnt     <= '0;
      prio         <= PRIO_W;
      rd_pending   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      state        <= state_next;
      init_cnt     <= init_cnt_next;
      prio         <= prio_next;
      rd_pending   <= r_accept;
      r_resp_valid <= rd_pending;
      // SRAM data is only meaningful the cycle after a read enable
      if (rd_pending) begin
        r_resp_data <= RW0_rdata;
      end
    end
  end

  // Port drive is gated by reset so the SRAM sees no enable while reset is held
  always_comb begin
    state_next    = state;
    init_cnt_next = init_cnt;
    prio_next     = prio;
    w_ready       = 1'b0;
    r_ready       = 1'b0;
    RW0_en        = 1'b0;
    RW0_wmode     = 1'b0;
    RW0_addr      = '0;
    RW0_wdata     = '0;
    RW0_wmask     = '0;
    if (!reset) begin
      case (state)
        ST_INIT: begin
          RW0_en    = 1'b1;
          RW0_wmode = 1'b1;
          RW0_addr  = init_cnt;
          RW0_wmask = '1;
          if (init_cnt == LAST_ADDR) begin
            state_next = ST_RUN;
          end else begin
            init_cnt_next = init_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          w_ready = w_valid && (!r_valid || (prio == PRIO_W));
          r_ready = r_valid && (!w_valid || (prio == PRIO_R));
          if (w_ready) begin
            RW0_en    = 1'b1;
            RW0_wmode = 1'b1;
            RW0_addr  = w_addr;
            RW0_wdata = w_data;
            RW0_wmask = w_mask;
            prio_next = PRIO_R;
          end else if (r_ready) begin
            RW0_en    = 1'b1;
            RW0_addr  = r_addr;
            prio_next = PRIO_W;
          end
        end
        default: begin
          state_next = RESET_STATE;
        end
      endcase
    end
  end

  assign r_accept  = r_valid && r_ready;
  assign init_done = (state == ST_RUN);

endmodule

// File: tb/tb_array_2_arb.sv
// Directed bench for array_2_arb with a behavioural single-port SRAM (latency 1, lane masks).
module tb_array_2_arb;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 76;
  localparam int MASK_W = 4;
  localparam int LANE_W = DATA_W / MASK_W;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clock;
  logic              reset;
  logic              w_valid, w_ready;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [MASK_W-1:0] w_mask;
  logic              r_valid, r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;
  logic              init_done;
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en, RW0_wmode;
  logic [DATA_W-1:0] RW0_wdata;
  logic [MASK_W-1:0] RW0_wmask;
  logic [DATA_W-1:0] RW0_rdata;

  int assert_count = 0;
  int fail_count   = 0;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdat [3];

  localparam logic [DATA_W-1:0] D_A  = 76'h1234_5678_9ABC_DEF0_123;
  localparam logic [DATA_W-1:0] D_X1 = 76'h0AA_55AA_55AA_55AA_55AA;
  localparam logic [DATA_W-1:0] D_X2 = 76'h123_4567_89AB_CDEF_0011;
  localparam logic [DATA_W-1:0] LANE1_ONES = {38'd0, 19'h7FFFF, 19'd0};

  array_2_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .INIT_EN(1)) dut (
    .clock(clock), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
    .r_resp_valid(r_resp_valid), .r_resp_data(r_resp_data), .init_done(init_done),
    .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
    .RW0_wdata(RW0_wdata), .RW0_wmask(RW0_wmask), .RW0_rdata(RW0_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (RW0_en) begin
      if (RW0_wmode) begin
        for (int l = 0; l < MASK_W; l++) begin
          if (RW0_wmask[l]) mem[RW0_addr][l*LANE_W +: LANE_W] <= RW0_wdata[l*LANE_W +: LANE_W];
        end
      end else begin
        RW0_rdata <= mem[RW0_addr];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; checks run 1 time unit later
  task automatic applyStimulus(input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                               input logic [MASK_W-1:0] wm, input logic rv, input logic [ADDR_W-1:0] ra);
    @(negedge clock);
    w_valid = wv; w_addr = wa; w_data = wd; w_mask = wm;
    r_valid = rv; r_addr = ra;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic runFill(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(negedge clock);
        #1;
      end
      checkOutput("fill_addr", RW0_addr, i);
      checkOutput("fill_ctl", {RW0_en, RW0_wmode, RW0_wmask, w_ready, r_ready, init_done}, 9'b11_1111_000);
      checkOutput("fill_wdata", RW0_wdata, '0);
    end
  endtask

  initial begin
    reset = 1'b1;
    w_valid = 1'b1; w_addr = 9'd3; w_data = D_A; w_mask = 4'hF;
    r_valid = 1'b1; r_addr = 9'd3;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("rst_ctl", {RW0_en, RW0_wmode, w_ready, r_ready, r_resp_valid, init_done}, 6'b0);
    checkOutput("rst_resp_data", r_resp_data, '0);

    @(negedge clock);
    reset = 1'b0;
    #1;
    runFill(DEPTH);
    idleCycle();
    checkOutput("init_done", init_done, 1'b1);
    checkOutput("idle_port", {RW0_en, RW0_wmode, RW0_wmask}, 6'b0);

    // Write then read of address 5
    applyStimulus(1'b1, 9'd5, D_A, 4'hF, 1'b0, '0);
    checkOutput("wr5_ready", {w_ready, r_ready}, 2'b10);
    checkOutput("wr5_port", {RW0_en, RW0_wmode, RW0_addr, RW0_wmask}, {1'b1, 1'b1, 9'd5, 4'hF});
    checkOutput("wr5_data", RW0_wdata, D_A);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 9'd5);
    checkOutput("rd5_ready", {w_ready, r_ready}, 2'b01);
    checkOutput("rd5_port", {RW0_en, RW0_wmode, RW0_addr, RW0_wmask}, {1'b1, 1'b0, 9'd5, 4'h0});
    idleCycle();
    checkOutput("rd5_t1", {r_resp_valid, RW0_en}, 2'b00);
    idleCycle();
    checkOutput("rd5_t2_valid", r_resp_valid, 1'b1);
    checkOutput("rd5_data", r_resp_data, D_A);
    idleCycle();
    checkOutput("rd5_t3_valid", r_resp_valid, 1'b0);
    checkOutput("rd5_hold", r_resp_data, D_A);

    // Both requesters valid: W, R, W, R
    applyStimulus(1'b1, 9'd10, D_X1, 4'hF, 1'b1, 9'd5);
    checkOutput("both_c1", {w_ready, r_ready}, 2'b10);
    applyStimulus(1'b1, 9'd11, D_X2, 4'hF, 1'b1, 9'd5);
    checkOutput("both_c2", {w_ready, r_ready}, 2'b01);
    applyStimulus(1'b1, 9'd11, D_X2, 4'hF, 1'b1, 9'd10);
    checkOutput("both_c3", {w_ready, r_ready}, 2'b10);
    checkOutput("both_c3_resp", r_resp_valid, 1'b0);
    applyStimulus(1'b1, 9'd12, D_X2, 4'hF, 1'b1, 9'd10);
    checkOutput("both_c4", {w_ready, r_ready}, 2'b01);
    checkOutput("both_c4_resp", {r_resp_valid, r_resp_data}, {1'b1, D_A});
    applyStimulus(1'b1, 9'd12, D_X2, 4'hF, 1'b0, '0);
    checkOutput("both_c5", {w_ready, r_ready, r_resp_valid}, 3'b100);
    idleCycle();
    checkOutput("both_c6_resp", {r_resp_valid, r_resp_data}, {1'b1, D_X1});

    // Lane mask over a zeroed word, then an all-zero mask
    applyStimulus(1'b1, 9'd7, '1, 4'b0010, 1'b0, '0);
    checkOutput("mask_wr", {w_ready, RW0_wmask}, 5'b1_0010);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 9'd7);
    idleCycle();
    idleCycle();
    checkOutput("mask_rd", {r_resp_valid, r_resp_data}, {1'b1, LANE1_ONES});
    applyStimulus(1'b1, 9'd7, '0, 4'b0000, 1'b0, '0);
    checkOutput("mask0_wr", {w_ready, RW0_en, RW0_wmode, RW0_wmask}, 7'b111_0000);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 9'd7);
    idleCycle();
    idleCycle();
    checkOutput("mask0_rd", {r_resp_valid, r_resp_data}, {1'b1, LANE1_ONES});

    // Back-to-back reads of 1, 2, 3
    rdat[0] = 76'h111_1111_1111_1111_1111;
    rdat[1] = 76'h222_2222_2222_2222_2222;
    rdat[2] = 76'h333_3333_3333_3333_3333;
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, ADDR_W'(k + 1), rdat[k], 4'hF, 1'b0, '0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, '0, '0, '0, (k < 3), ADDR_W'(k + 1));
      if (k < 3) checkOutput("b2b_ready", r_ready, 1'b1);
      checkOutput("b2b_valid", r_resp_valid, (k >= 2 && k <= 4));
      if (k >= 2 && k <= 4) checkOutput("b2b_data", r_resp_data, rdat[k-2]);
    end

    // Reset in RUN, then again in the middle of the fill at counter 200
    @(negedge clock);
    reset = 1'b1; w_valid = 1'b1; r_valid = 1'b1; w_addr = 9'd3; r_addr = 9'd3;
    #1;
    checkOutput("rst2_ctl", {RW0_en, RW0_wmode, w_ready, r_ready, r_resp_valid, init_done}, 6'b0);
    checkOutput("rst2_resp_data", r_resp_data, '0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    runFill(201);
    reset = 1'b1;
    #1;
    checkOutput("rst200_ctl", {RW0_en, init_done}, 2'b00);
    @(negedge clock);
    reset = 1'b0;
    #1;
    runFill(DEPTH);
    idleCycle();
    checkOutput("init_done2", init_done, 1'b1);

    // Reset one cycle after a read is accepted
    applyStimulus(1'b1, 9'd4, D_A, 4'hF, 1'b0, '0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 9'd4);
    checkOutput("rdrst_ready", r_ready, 1'b1);
    @(negedge clock);
    r_valid = 1'b0; reset = 1'b1;
    #1;
    checkOutput("rdrst_valid_in_reset", r_resp_valid, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clock);
        #1;
      end
      checkOutput("rdrst_valid", r_resp_valid, 1'b0);
      checkOutput("rdrst_fill_addr", RW0_addr, i);
      checkOutput("rdrst_resp_data", r_resp_data, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
